des_sbox_seq: RTL and testbench
===============================

# des_sbox_seq

Parametrised, time-multiplexed DES substitution unit. It accepts a 48-bit expanded-and-key-mixed half-block and applies all eight DES S-boxes (S1..S8), PAR boxes per cycle. It returns the 32-bit substituted word, pre-P-permutation, over a valid/ready handshake on both sides. It sits between the expansion/key-XOR stage and the P-permutation in the round datapath, and trades area against throughput.

## Interface
- PAR, 2, S-box lookups per cycle; legal values 1, 2, 4, 8; any other value is a fatal elaboration error.
- clk  in  1  clock; everything is rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept an input word.
- in_data  in  48  input word; bits [47:42] feed S1, and so on down to bits [5:0], which feed S8.
- out_valid  out  1  out_data holds a completed result.
- out_ready  in  1  downstream accepts the result.
- out_data  out  32  result; bits [31:28] come from S1, and so on down to bits [3:0], which come from S8.

## Operation
- Per box, the 6-bit input b[5:0] is decoded as:
  - row = {b[5], b[0]}
  - column = b[4:1]
  - output = standard DES table entry.
- FSM states: IDLE, BUSY, DONE. A 3-bit group counter `grp` (0..8/PAR-1) runs in BUSY.
- IDLE:
  - in_ready = 1.
  - On in_valid: capture in_data into `work`, set grp = 0, go to BUSY.
- BUSY:
  - in_ready = 0, out_valid = 0.
  - Each cycle, boxes grp*PAR+1 .. grp*PAR+PAR are looked up from `work`, and their nibbles are written into the result register at their final positions.
  - If grp == 8/PAR-1, go to DONE; otherwise grp increments.
- DONE:
  - out_valid = 1; out_data is stable until accepted.
  - in_ready = out_ready. This allows back-to-back operation.
  - out_ready && in_valid: capture the new word, grp = 0, go to BUSY (no IDLE bubble).
  - out_ready && !in_valid: go to IDLE.
  - !out_ready: hold state and all outputs.
- in_data is sampled only on an accepted handshake. Changes to in_data outside the handshake have no effect.
- The result register is not cleared between words. Every nibble is rewritten before DONE.

## Timing
- Reset values:
  - state = IDLE, grp = 0.
  - out_valid = 0, out_data = 32'h0.
  - in_ready = 0 while rst is high, and 1 in the first cycle after rst falls.
- Latency: input accepted at edge N gives out_valid high from edge N + 8/PAR.
  - PAR = 8: 1 cycle.
  - PAR = 1: 8 cycles.
- Throughput with out_ready tied high: one word every 8/PAR + 1 cycles.
- Reset asserted mid-operation (BUSY or DONE): the word in flight is discarded, with no output handshake. The state at the next edge is IDLE with the reset values above.
- in_ready and out_valid are functions of registered state plus out_ready only. There is no combinational path from in_valid to any output.

## Configuration
- Macro: DES_SBOX_KEYMIX_EN.
- Defined:
  - Adds port `in_key  in  48  round subkey`.
  - The captured word is in_data ^ in_key, sampled on the same handshake.
  - The upstream XOR stage may be removed.
- Undefined:
  - The port is absent.
  - The captured word is in_data unchanged.
- Latency and handshake are identical in both builds.

## Structure
- Package des_pkg holds:
  - The constant table SBOX[8][64] of 4-bit entries, indexed by raw 6-bit input (row/column decode folded in).
  - The state enum typedef.
  - The localparam NGRP = 8/PAR is computed in the module itself.
- Sub-module des_sbox_lut:
  - Combinational.
  - Inputs: box index (3 bits), 6-bit input. Output: 4-bit result.
  - Instantiated PAR times; instance i is driven with box index grp*PAR+i.

## Test plan
- PAR = 8, in_data = 48'h0 → out_data = 32'hEFA72C4D one cycle after acceptance.
- PAR = 1, in_data = 48'hFFFF_FFFF_FFFF → out_data = 32'hD9CE3DCB, with out_valid rising exactly 8 cycles after acceptance.
- PAR = 2, out_ready tied high, 16 random words streamed with in_valid held high:
  - Results match the golden model.
  - Accepts are 5 cycles apart.
  - No IDLE cycle occurs between words.
- PAR = 4, out_ready held low for 10 cycles in DONE:
  - out_valid and out_data stay constant.
  - in_ready = 0.
  - Releasing out_ready with in_valid high accepts the next word in the same cycle.
- PAR = 2, rst pulsed during BUSY grp = 2:
  - Next cycle: out_valid = 0, out_data = 0, state IDLE.
  - The following word returns the correct result.
- DES_SBOX_KEYMIX_EN defined, in_data = in_key = 48'h1234_5678_9ABC → out_data = 32'hEFA72C4D.

Source files
------------

// File: rtl/des_pkg.sv
// Shared constants and types for the time-multiplexed DES S-box unit.
// Latency: none (package only).
// Backpressure: not applicable.
package des_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  // Folded table: SBOX[box][raw 6-bit input] -> 4-bit output.
  typedef logic [7:0][63:0][3:0] sbox_tbl_t;

  // Standard DES S-box rows, one 64-bit word per row, column 0 in the top nibble.
  localparam logic [63:0] SBOX_ROWS [8][4] = '{
    '{64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
    '{64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
    '{64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
    '{64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
    '{64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
    '{64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
    '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
    '{64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}
  };

  // Re-index every box by its raw input so the datapath needs no row/column decode.
  function automatic sbox_tbl_t fold_sbox();
    sbox_tbl_t  t;
    logic [5:0] b;
    logic [1:0] row;
    logic [3:0] col;
    t = '0;
    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < 64; i++) begin
        b   = 6'(i);
        row = {b[5], b[0]};
        col = b[4:1];
        t[s][i] = SBOX_ROWS[s][row][(15 - int'(col)) * 4 +: 4];
      end
    end
    return t;
  endfunction

  localparam sbox_tbl_t SBOX = fold_sbox();

endpackage

// File: rtl/des_sbox_lut.sv
// One DES S-box lookup, box selected at run time.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module des_sbox_lut
  import des_pkg::*;
(
  input  logic [2:0] box,
  input  logic [5:0] din,
  output logic [3:0] dout
);

  assign dout = SBOX[box][din];

endmodule

// File: rtl/des_sbox_seq.sv
// Time-multiplexed DES S1..S8 substitution, PAR boxes per cycle (optional key XOR: DES_SBOX_KEYMIX_EN).
// Latency: 8/PAR cycles from input accept to out_valid; one word every 8/PAR+1 cycles.
// Backpressure: result held stable while out_ready is low; in_ready follows out_ready in DONE.
module des_sbox_seq
  import des_pkg::*;
#(
  parameter int PAR = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] in_data,
`ifdef DES_SBOX_KEYMIX_EN
  input  logic [47:0] in_key,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  localparam int         NGRP     = 8 / PAR;
  localparam logic [2:0] LAST_GRP = 3'(NGRP - 1);

  if (!(PAR == 1 || PAR == 2 || PAR == 4 || PAR == 8)) begin : g_bad_par
    $fatal(1, "des_sbox_seq: PAR must be 1, 2, 4 or 8");
  end

  state_t      state_q, state_d;
  logic [2:0]  grp_q;
  logic [47:0] work_q;
  logic [31:0] res_q;
  logic [47:0] word_in;
  logic        accept;

  logic [2:0]  box_idx [PAR];
  logic [5:0]  box_in  [PAR];
  logic [3:0]  box_out [PAR];

`ifdef DES_SBOX_KEYMIX_EN
  assign word_in = in_data ^ in_key;
`else
  assign word_in = in_data;
`endif

  // Instance i serves box grp*PAR+i; its 6 input bits come from that box's slot in work.
  for (genvar i = 0; i < PAR; i++) begin : g_lut
    assign box_idx[i] = 3'(int'(grp_q) * PAR + i);
    assign box_in[i]  = work_q[47 - 6 * int'(box_idx[i]) -: 6];
    des_sbox_lut u_lut (
      .box  (box_idx[i]),
      .din  (box_in[i]),
      .dout (box_out[i])
    );
  end

  // Next state and handshake outputs; depend only on state, out_ready and rst.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && in_ready) state_d = BUSY;
      end
      BUSY: begin
        if (grp_q == LAST_GRP) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready && !rst;
        if (out_ready) state_d = in_valid ? BUSY : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept   = in_valid && in_ready;
  assign out_data = res_q;

  // State, group counter, captured word and result nibbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grp_q   <= '0;
      work_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        work_q <= word_in;
        grp_q  <= '0;
      end else if (state_q == BUSY && grp_q != LAST_GRP) begin
        grp_q <= grp_q + 3'd1;
      end
      if (state_q == BUSY) begin
        for (int i = 0; i < PAR; i++) begin
          res_q[31 - 4 * int'(box_idx[i]) -: 4] <= box_out[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_des_sbox_seq.sv
// Bench for des_sbox_seq: four instances (PAR = 1, 2, 4, 8) on shared stimulus.
// Reference model decodes row/column from the standard DES tables.
// Each scenario task checks its own results inline.
module tb_des_sbox_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [47:0] in_data;
  logic        out_ready;
  logic [47:0] cur_key = '0;
  logic        rdy [4];
  logic        vld [4];
  logic [31:0] dat [4];

  int vectors     = 0;
  int miscompares = 0;

`ifdef DES_SBOX_KEYMIX_EN
  logic [47:0] in_key;
  assign in_key = cur_key;
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    des_sbox_seq #(.PAR(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (rdy[g]),
      .in_data   (in_data),
`ifdef DES_SBOX_KEYMIX_EN
      .in_key    (in_key),
`endif
      .out_valid (vld[g]),
      .out_ready (out_ready),
      .out_data  (dat[g])
    );
  end

  // Standard DES tables: TBL[box][row], column 0 in the top nibble.
  logic [63:0] TBL [8][4] = '{
    '{64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
    '{64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
    '{64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
    '{64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
    '{64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
    '{64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
    '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
    '{64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}
  };

  function automatic logic [31:0] ref_sbox(input logic [47:0] w);
    logic [31:0] r;
    logic [5:0]  b;
    logic [63:0] row_word;
    int          row, col;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      b        = w[47 - 6 * k -: 6];
      row      = (b[5] ? 2 : 0) + (b[0] ? 1 : 0);
      col      = int'(b[4:1]);
      row_word = TBL[k][row] >> (4 * (15 - col));
      r[31 - 4 * k -: 4] = row_word[3:0];
    end
    return r;
  endfunction

  function automatic logic [47:0] rand48();
    return 48'({$urandom(), $urandom()});
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    @(posedge clk); #1;
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      vectors++;
      if (rdy[d] !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready dut%0d got %b want 0", d, rdy[d]); end
      vectors++;
      if (vld[d] !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid dut%0d got %b want 0", d, vld[d]); end
      vectors++;
      if (dat[d] !== 32'h0) begin miscompares++; $display("FAIL reset_out_data dut%0d got %h want 0", d, dat[d]); end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      vectors++;
      if (rdy[d] !== 1'b1) begin miscompares++; $display("FAIL post_reset_in_ready dut%0d got %b want 1", d, rdy[d]); end
    end
    @(posedge clk); #1;
  endtask

  // Accept one word on dut idx (all DUTs idle), then measure latency and result.
  task automatic test_latency(input int idx, input logic [47:0] word, input logic [31:0] expd);
    int n;
    bit got;
    int want_lat;
    want_lat = 8 >> idx;
    in_data = word; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (rdy[idx] !== 1'b1) begin miscompares++; $display("FAIL accept_ready dut%0d got %b want 1", idx, rdy[idx]); end
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = rand48();
    n = 0; got = 0;
    while (!got && n <= 20) begin
      @(negedge clk);
      if (vld[idx] === 1'b1) got = 1;
      else begin @(posedge clk); #1; in_data = rand48(); n++; end
    end
    vectors++;
    if (!got || n != want_lat) begin
      miscompares++; $display("FAIL latency dut%0d got %0d (seen %0d) want %0d", idx, n, got, want_lat);
    end
    vectors++;
    if (dat[idx] !== expd) begin miscompares++; $display("FAIL result dut%0d word %h got %h want %h", idx, word, dat[idx], expd); end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_random();
    logic [47:0] w;
    for (int d = 0; d < 4; d++) begin
      for (int r = 0; r < 3; r++) begin
        w = rand48();
`ifdef DES_SBOX_KEYMIX_EN
        cur_key = rand48();
`endif
        test_latency(d, w, ref_sbox(w ^ cur_key));
      end
    end
    cur_key = '0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] expq[$];
    logic [31:0] e;
    int accepts, results, idle_cycles, last_acc, cyc;
    bit acc;
    do_reset();
    accepts = 0; results = 0; idle_cycles = 0; last_acc = 0; cyc = 0;
    out_ready = 1'b1; in_valid = 1'b1; in_data = rand48();
    while (results < 16 && cyc < 300) begin
      @(negedge clk);
      acc = (rdy[1] === 1'b1) && in_valid;
      if (vld[1] === 1'b1) begin
        e = expq.size() > 0 ? expq.pop_front() : 32'hx;
        vectors++;
        if (dat[1] !== e) begin miscompares++; $display("FAIL b2b_result #%0d got %h want %h", results, dat[1], e); end
        results++;
      end
      if (rdy[1] === 1'b1 && vld[1] !== 1'b1 && accepts > 0 && accepts < 16) idle_cycles++;
      if (acc) begin
        expq.push_back(ref_sbox(in_data));
        if (accepts > 0) begin
          vectors++;
          if (cyc - last_acc != 5) begin miscompares++; $display("FAIL b2b_gap #%0d got %0d want 5", accepts, cyc - last_acc); end
        end
        last_acc = cyc;
        accepts++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        if (accepts == 16) in_valid = 1'b0;
        else in_data = rand48();
      end
    end
    vectors++;
    if (results != 16) begin miscompares++; $display("FAIL b2b_count got %0d want 16", results); end
    vectors++;
    if (idle_cycles != 0) begin miscompares++; $display("FAIL b2b_idle got %0d want 0", idle_cycles); end
    drain();
  endtask

  task automatic test_hold();
    logic [47:0] w1, w2;
    logic [31:0] e1;
    int n;
    do_reset();
    w1 = rand48(); w2 = rand48(); e1 = ref_sbox(w1);
    in_data = w1; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (vld[2] !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    vectors++;
    if (vld[2] !== 1'b1) begin miscompares++; $display("FAIL hold_reach_done got %b want 1", vld[2]); end
    in_data = w2; in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      vectors++;
      if (vld[2] !== 1'b1) begin miscompares++; $display("FAIL hold_valid cyc%0d got %b want 1", c, vld[2]); end
      vectors++;
      if (dat[2] !== e1) begin miscompares++; $display("FAIL hold_data cyc%0d got %h want %h", c, dat[2], e1); end
      vectors++;
      if (rdy[2] !== 1'b0) begin miscompares++; $display("FAIL hold_in_ready cyc%0d got %b want 0", c, rdy[2]); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (rdy[2] !== 1'b1) begin miscompares++; $display("FAIL release_in_ready got %b want 1", rdy[2]); end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0; in_data = rand48();
    @(negedge clk);
    vectors++;
    if (vld[2] !== 1'b0) begin miscompares++; $display("FAIL release_busy_valid got %b want 0", vld[2]); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (vld[2] !== 1'b1) begin miscompares++; $display("FAIL second_valid got %b want 1", vld[2]); end
    vectors++;
    if (dat[2] !== ref_sbox(w2)) begin miscompares++; $display("FAIL second_data got %h want %h", dat[2], ref_sbox(w2)); end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_reset_mid();
    logic [47:0] w;
    do_reset();
    w = rand48();
    in_data = w; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (vld[1] !== 1'b0) begin miscompares++; $display("FAIL midrst_valid got %b want 0", vld[1]); end
    vectors++;
    if (dat[1] !== 32'h0) begin miscompares++; $display("FAIL midrst_data got %h want 0", dat[1]); end
    vectors++;
    if (rdy[1] !== 1'b1) begin miscompares++; $display("FAIL midrst_idle_ready got %b want 1", rdy[1]); end
    @(posedge clk); #1;
    w = rand48();
    test_latency(1, w, ref_sbox(w));
  endtask

`ifdef DES_SBOX_KEYMIX_EN
  task automatic test_keymix();
    do_reset();
    cur_key = 48'h1234_5678_9ABC;
    test_latency(3, 48'h1234_5678_9ABC, 32'hEFA72C4D);
    test_latency(0, 48'h1234_5678_9ABC, 32'hEFA72C4D);
    cur_key = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_latency(3, 48'h0, 32'hEFA72C4D);
    test_latency(0, 48'hFFFF_FFFF_FFFF, 32'hD9CE3DCB);
    test_random();
    test_back_to_back();
    test_hold();
    test_reset_mid();
`ifdef DES_SBOX_KEYMIX_EN
    test_keymix();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired after 50000 cycles");
    $fatal(1, "watchdog");
  end

endmodule
